// File: rtl/hier_fanin_node_pkg.sv
// Shared definitions for the hierarchy fan-in node and its arbiter.
package hier_node_pkg;

  // Widest fan-in any node instance is expected to support.
  localparam int MAX_CH = 16;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy width for the default FIFO depth.
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_OCC_W = occ_width(DEFAULT_DEPTH);

  // Channel tag wide enough for the largest supported fan-in.
  localparam int MAX_CH_W = clog2_min1(MAX_CH);
  typedef logic [MAX_CH_W-1:0] ch_tag_t;

endpackage

// File: rtl/hier_fanin_node_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the
// rotating pointer, and moves the pointer past the winner on advance.
module rr_arbiter
  import hier_node_pkg::*;
#(
  parameter int N = 5,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  // Search upward from rr_ptr with wrap; the first requester found wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Pointer moves to the channel after the winner, only when a grant is used.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && (|req)) begin
      if (grant_idx == IDX_W'(N - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + IDX_W'(1);
      end
    end
  end

  // Pointer register, cleared so the first search after reset starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/hier_fanin_node.sv
// Hierarchy fan-in node: NUM_CH buffered child channels merged by a
// round-robin arbiter into one registered, channel-tagged output stream.
module hier_fanin_node
  import hier_node_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [NUM_CH*OCC_W-1:0]  occ
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   grant_idx;
  logic              load;
  logic [DATA_W-1:0] head [NUM_CH];

  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   out_ch_d;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign pop = load ? grant : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [OCC_W-1:0]  count_q;
    logic [OCC_W-1:0]  count_d;
    logic              push;

    // Ready looks only at the registered count, so a full FIFO stays
    // closed during the cycle it is popped; reset also holds it closed.
    assign in_ready[i] = rst_n && ch_en[i] && (count_q < OCC_W'(DEPTH));
    assign push        = in_valid[i] && in_ready[i];
    assign req[i]      = ch_en[i] && (count_q != '0);
    assign head[i]     = mem_q[rd_ptr_q];
    assign occ[i*OCC_W +: OCC_W] = count_q;

    // Next FIFO state: write at the tail, read from the head, pointers wrap.
    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
        mem_d[wr_ptr_q] = in_data[i*DATA_W +: DATA_W];
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop[i]})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end

    // FIFO storage and pointers; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[k] <= '0;
        end
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end
  end

  // Output register loads a granted head when empty or being drained;
  // otherwise it drops valid on a taken beat or holds under backpressure.
  always_comb begin
    logic [DATA_W-1:0] sel_data;
    load     = (!out_valid_q || out_ready) && (|req);
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | head[i];
      end
    end
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stream registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
